// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver states, oversampling sample points and baud divisors.
// The transmit path imports the same rate table so both ends agree on bit timing.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_e;

    localparam int OVERSAMPLE = 16;

    localparam logic [3:0] SMP_VOTE_A = 4'd7;
    localparam logic [3:0] SMP_VOTE_B = 4'd8;
    localparam logic [3:0] SMP_DECIDE = 4'd9;
    localparam logic [3:0] SMP_LAST   = 4'd15;

    localparam int BAUD_9600   = 9600;
    localparam int BAUD_19200  = 19200;
    localparam int BAUD_57600  = 57600;
    localparam int BAUD_115200 = 115200;

    localparam int DIV_W = 16;

    function automatic int baud_rate(input logic [1:0] sel);
        int rate;
        case (sel)
            2'b00:   rate = BAUD_9600;
            2'b01:   rate = BAUD_19200;
            2'b10:   rate = BAUD_57600;
            default: rate = BAUD_115200;
        endcase
        return rate;
    endfunction

    // Clocks per oversample tick, rounded to nearest.
    function automatic int baud_div(input int clk_freq, input logic [1:0] sel);
        int rate;
        rate = baud_rate(sel);
        return (clk_freq + rate * (OVERSAMPLE / 2)) / (rate * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_rx_os16_if.sv
// Receiver-side bundle: line input, rate controls and received-byte outputs.
// The master drives the line and controls; the slave is the receive engine.
interface uart_rx_os16_if;
    logic [1:0] baud_sel;
    logic       enable_baud;
    logic       rxd;
    logic [7:0] o_data;
    logic       o_data_valid;
    logic       o_frame_err;
    logic       rx_busy;

    modport master (
        output baud_sel, enable_baud, rxd,
        input  o_data, o_data_valid, o_frame_err, rx_busy
    );

    modport slave (
        input  baud_sel, enable_baud, rxd,
        output o_data, o_data_valid, o_frame_err, rx_busy
    );
endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clock tick every baud_div() clocks.
// Held at zero while disabled and restarted whenever the rate select changes.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable_i,
    input  logic [1:0] baud_sel_i,
    output logic       tick_o
);

    localparam logic [DIV_W-1:0] DIV_M1_0 = DIV_W'(baud_div(CLK_FREQ, 2'b00) - 1);
    localparam logic [DIV_W-1:0] DIV_M1_1 = DIV_W'(baud_div(CLK_FREQ, 2'b01) - 1);
    localparam logic [DIV_W-1:0] DIV_M1_2 = DIV_W'(baud_div(CLK_FREQ, 2'b10) - 1);
    localparam logic [DIV_W-1:0] DIV_M1_3 = DIV_W'(baud_div(CLK_FREQ, 2'b11) - 1);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_m1;
    logic [1:0]       sel_q;
    logic             sel_changed;

    always_comb begin
        case (baud_sel_i)
            2'b00:   div_m1 = DIV_M1_0;
            2'b01:   div_m1 = DIV_M1_1;
            2'b10:   div_m1 = DIV_M1_2;
            default: div_m1 = DIV_M1_3;
        endcase
    end

    assign sel_changed = (baud_sel_i != sel_q);
    assign tick_o      = enable_i && !sel_changed && (cnt_q == div_m1);

    // NOTE: every path assigns cnt_d, so this block stays purely combinational.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (!enable_i || sel_changed || tick_o) begin
            cnt_d = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            sel_q <= 2'b00;
        end else begin
            cnt_q <= cnt_d;
            sel_q <= baud_sel_i;
        end
    end

endmodule

// File: rtl/uart_rx_os16.sv
// 8N1 UART receiver with 16x oversampling, 2-flop input synchronizer and 3-sample
// majority vote; rejects start-bit glitches and holds off restart after a framing error.
module uart_rx_os16 #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
    input  logic           clk,
    input  logic           rst,
    uart_rx_os16_if.slave  rx_if
);
    import uart_pkg::*;

    localparam int CNT_W = $clog2(OVERSAMPLE);

    logic             tick;
    logic [1:0]       sync_q;
    logic             rxs;
    logic             maj;
    rx_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic [1:0]       vote_q;
    logic [7:0]       data_q;
    logic             valid_q;
    logic             ferr_q;
    logic             busy_q;

    uart_baud_tick #(
        .CLK_FREQ(CLK_FREQ)
    ) u_tick (
        .clk        (clk),
        .rst        (rst),
        .enable_i   (rx_if.enable_baud),
        .baud_sel_i (rx_if.baud_sel),
        .tick_o     (tick)
    );

    // Synchronizer resets to the idle-high line level so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx_if.rxd};
        end
    end

    assign rxs = sync_q[1];
    assign maj = (vote_q[0] & vote_q[1]) | (vote_q[0] & rxs) | (vote_q[1] & rxs);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            vote_q    <= 2'b11;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            // NOTE: pulses default low each clock so a set lasts exactly one cycle.
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            if (!rx_if.enable_baud) begin
                state_q   <= IDLE;
                busy_q    <= 1'b0;
                cnt_q     <= '0;
                bit_idx_q <= '0;
            end else if (tick) begin
                cnt_q <= cnt_q + 1'b1;
                if (cnt_q == SMP_VOTE_A) vote_q[0] <= rxs;
                if (cnt_q == SMP_VOTE_B) vote_q[1] <= rxs;
                case (state_q)
                    IDLE: begin
                        if (!rxs) begin
                            state_q <= START;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                        end
                    end
                    START: begin
                        if (cnt_q == SMP_DECIDE && maj) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else if (cnt_q == SMP_LAST) begin
                            state_q   <= DATA;
                            bit_idx_q <= '0;
                        end
                    end
                    DATA: begin
                        if (cnt_q == SMP_DECIDE) shift_q[bit_idx_q] <= maj;
                        if (cnt_q == SMP_LAST) begin
                            if (bit_idx_q == 3'd7) state_q <= STOP;
                            else                   bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end
                    STOP: begin
                        // Leaving at mid-stop lets a back-to-back start edge be caught cleanly.
                        if (cnt_q == SMP_DECIDE) begin
                            if (maj) begin
                                data_q  <= shift_q;
                                valid_q <= 1'b1;
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end else begin
                                ferr_q  <= 1'b1;
                                state_q <= BREAK;
                            end
                        end
                    end
                    BREAK: begin
                        if (rxs) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rx_if.o_data       = data_q;
    assign rx_if.o_data_valid = valid_q;
    assign rx_if.o_frame_err  = ferr_q;
    assign rx_if.rx_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_os16.sv
// Directed bench for uart_rx_os16: good frames, glitch, framing error, back-to-back,
// reset/enable aborts and rate switching, with pulses logged by a negedge monitor.
module tb_uart_rx_os16;

    // The receiver runs at 25 MHz here so all rates fit a short run; divisors are
    // DIV = 163/81/27/14, giving 16*DIV clocks per bit.
    localparam int TB_CLK_FREQ = 25_000_000;
    localparam int DIV_9600    = 163;
    localparam int BIT_9600    = 2608;
    localparam int BIT_19200   = 1296;
    localparam int BIT_57600   = 432;
    localparam int BIT_115200  = 224;

    logic clk = 1'b0;
    logic rst;

    always #20 clk = ~clk;

    uart_rx_os16_if rx_if ();

    uart_rx_os16 #(
        .CLK_FREQ   (TB_CLK_FREQ),
        .OVERSAMPLE (16)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .rx_if (rx_if)
    );

    int compared   = 0;
    int mismatched = 0;

    int         cyc       = 0;
    int         valid_cnt = 0;
    int         ferr_cnt  = 0;
    int         viol_cnt  = 0;
    int         valid_cyc = 0;
    logic       busy_at_valid = 1'b1;
    logic       prev_pulse    = 1'b0;
    logic [7:0] data_log [32];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_if.o_data_valid === 1'b1) begin
            data_log[valid_cnt % 32] = rx_if.o_data;
            valid_cnt++;
            valid_cyc     = cyc;
            busy_at_valid = rx_if.rx_busy;
        end
        if (rx_if.o_frame_err === 1'b1) ferr_cnt++;
        if ((rx_if.o_data_valid === 1'b1 && rx_if.o_frame_err === 1'b1) ||
            ((rx_if.o_data_valid === 1'b1 || rx_if.o_frame_err === 1'b1) && prev_pulse))
            viol_cnt++;
        prev_pulse = (rx_if.o_data_valid === 1'b1) || (rx_if.o_frame_err === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bits(input logic [9:0] frame, input int nbits, input int bit_clk);
        for (int i = 0; i < nbits; i++) begin
            rx_if.rxd = frame[i];
            repeat (bit_clk) @(negedge clk);
        end
    endtask

    task automatic send_byte(input logic [7:0] data, input logic stop, input int bit_clk);
        drive_bits({stop, data, 1'b0}, 10, bit_clk);
    endtask

    int v0;
    int f0;
    int t0;
    int lat;

    initial begin
        rst               = 1'b1;
        rx_if.rxd         = 1'b1;
        rx_if.enable_baud = 1'b1;
        rx_if.baud_sel    = 2'b00;
        repeat (3) @(negedge clk);
        check("rst_o_data", rx_if.o_data, 8'h00);
        check("rst_valid", rx_if.o_data_valid, 1'b0);
        check("rst_frame_err", rx_if.o_frame_err, 1'b0);
        check("rst_busy", rx_if.rx_busy, 1'b0);
        rst = 1'b0;

        check("div_50M_9600", uart_pkg::baud_div(50_000_000, 2'b00), 326);
        check("div_50M_19200", uart_pkg::baud_div(50_000_000, 2'b01), 163);
        check("div_50M_57600", uart_pkg::baud_div(50_000_000, 2'b10), 54);
        check("div_50M_115200", uart_pkg::baud_div(50_000_000, 2'b11), 27);
        repeat (20) @(negedge clk);

        // Good frame 0xA5 at 9600
        v0 = valid_cnt; f0 = ferr_cnt; t0 = cyc;
        send_byte(8'hA5, 1'b1, BIT_9600);
        lat = valid_cyc - t0;
        check("a5_valid_count", valid_cnt - v0, 1);
        check("a5_data", data_log[v0 % 32], 8'hA5);
        check("a5_o_data_held", rx_if.o_data, 8'hA5);
        check("a5_no_frame_err", ferr_cnt - f0, 0);
        check("a5_busy_drops_with_pulse", busy_at_valid, 1'b0);
        check("a5_latency_window", (lat >= 154 * DIV_9600) && (lat <= 155 * DIV_9600 + 4), 1);
        check("a5_idle_after", rx_if.rx_busy, 1'b0);

        // Glitch rejection at 115200: 3 ticks low
        rx_if.baud_sel = 2'b11;
        repeat (50) @(negedge clk);
        v0 = valid_cnt; f0 = ferr_cnt;
        rx_if.rxd = 1'b0;
        repeat (42) @(negedge clk);
        rx_if.rxd = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_busy_in_start", rx_if.rx_busy, 1'b1);
        repeat (200) @(negedge clk);
        check("glitch_busy_cleared", rx_if.rx_busy, 1'b0);
        check("glitch_no_valid", valid_cnt - v0, 0);
        check("glitch_no_frame_err", ferr_cnt - f0, 0);
        send_byte(8'h5A, 1'b1, BIT_115200);
        check("5a_valid_count", valid_cnt - v0, 1);
        check("5a_data", data_log[v0 % 32], 8'h5A);

        // Framing error then 3 bit-times of break
        v0 = valid_cnt; f0 = ferr_cnt;
        send_byte(8'h3C, 1'b0, BIT_115200);
        repeat (3 * BIT_115200) @(negedge clk);
        check("ferr_pulse_count", ferr_cnt - f0, 1);
        check("ferr_no_valid", valid_cnt - v0, 0);
        check("ferr_o_data_kept", rx_if.o_data, 8'h5A);
        check("ferr_busy_in_break", rx_if.rx_busy, 1'b1);
        rx_if.rxd = 1'b1;
        repeat (60) @(negedge clk);
        check("ferr_busy_released", rx_if.rx_busy, 1'b0);
        repeat (2 * BIT_115200) @(negedge clk);
        check("ferr_no_further_err", ferr_cnt - f0, 1);
        check("ferr_no_further_valid", valid_cnt - v0, 0);

        // Back-to-back frames, no idle gap
        v0 = valid_cnt;
        send_byte(8'h3C, 1'b1, BIT_115200);
        send_byte(8'hC3, 1'b1, BIT_115200);
        check("b2b_valid_count", valid_cnt - v0, 2);
        check("b2b_first", data_log[v0 % 32], 8'h3C);
        check("b2b_second", data_log[(v0 + 1) % 32], 8'hC3);

        // Reset during data bit 4 of 0xFF
        v0 = valid_cnt; f0 = ferr_cnt;
        drive_bits({1'b1, 8'hFF, 1'b0}, 5, BIT_115200);
        rx_if.rxd = 1'b1;
        repeat (BIT_115200 / 2) @(negedge clk);
        check("rst_abort_busy_before", rx_if.rx_busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_abort_busy_after", rx_if.rx_busy, 1'b0);
        check("rst_abort_o_data_cleared", rx_if.o_data, 8'h00);
        repeat (6 * BIT_115200) @(negedge clk);
        check("rst_abort_no_valid", valid_cnt - v0, 0);
        check("rst_abort_no_frame_err", ferr_cnt - f0, 0);

        // enable_baud dropped mid-frame
        drive_bits({1'b1, 8'hFF, 1'b0}, 5, BIT_115200);
        rx_if.rxd = 1'b1;
        repeat (BIT_115200 / 2) @(negedge clk);
        check("en_abort_busy_before", rx_if.rx_busy, 1'b1);
        rx_if.enable_baud = 1'b0;
        @(negedge clk);
        check("en_abort_idle_next_clk", rx_if.rx_busy, 1'b0);
        repeat (6 * BIT_115200) @(negedge clk);
        rx_if.enable_baud = 1'b1;
        repeat (BIT_115200) @(negedge clk);
        check("en_abort_no_valid", valid_cnt - v0, 0);
        check("en_abort_no_frame_err", ferr_cnt - f0, 0);
        check("en_abort_o_data_kept", rx_if.o_data, 8'h00);
        send_byte(8'h81, 1'b1, BIT_115200);
        check("81_valid_count", valid_cnt - v0, 1);
        check("81_data", data_log[v0 % 32], 8'h81);

        // Rate switch while idle: 19200 then 57600
        rx_if.baud_sel = 2'b01;
        repeat (100) @(negedge clk);
        v0 = valid_cnt;
        send_byte(8'h55, 1'b1, BIT_19200);
        check("55_valid_count", valid_cnt - v0, 1);
        check("55_data", data_log[v0 % 32], 8'h55);
        rx_if.baud_sel = 2'b10;
        repeat (100) @(negedge clk);
        send_byte(8'hAA, 1'b1, BIT_57600);
        check("aa_valid_count", valid_cnt - v0, 2);
        check("aa_data", data_log[(v0 + 1) % 32], 8'hAA);
        check("aa_o_data", rx_if.o_data, 8'hAA);

        check("pulses_exclusive_nonadjacent", viol_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
